// File: rtl/ircam_frame_tx.sv
// ircam_frame_tx: serialises one thermal-camera frame over an 8N1 UART line.
// Frame = 5A 5A 02 06, NUM_PIX pixel words, ambient word, checksum word (all LE).
module ircam_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int NUM_PIX      = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [15:0] ambient,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [9:0]  pix_index,
    output logic        UART_TX,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [3:0] {
        IDLE, HDR, WAIT_PIX, PIX_LO, PIX_HI, AMB_LO, AMB_HI, CHK_LO, CHK_HI, LAST
    } state_t;

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [10:0]    PIX_END  = 11'(NUM_PIX);
    // 0x5A5A + 0x0602: the fixed header's contribution to the checksum
    localparam logic [15:0]    HDR_SUM  = 16'h605C;

    state_t        r_state, w_next;
    logic [CW-1:0] r_clk_cnt;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic          r_active;
    logic [1:0]    r_byte_cnt;
    logic [10:0]   r_idx;
    logic [15:0]   r_pix, r_amb, r_sum;
    logic          w_byte_end, w_tx_ready, w_load;
    logic [7:0]    w_byte;
    logic [15:0]   w_chk;

    // The shifter can take a new byte while idle or during the last cycle of a stop bit
    assign w_byte_end = r_active && (r_bit_cnt == 4'd9) && (r_clk_cnt == CNT_MAX);
    assign w_tx_ready = !r_active || w_byte_end;
    assign w_chk      = r_sum + HDR_SUM + r_amb;

    assign UART_TX    = r_active ? r_shift[0] : 1'b1;
    assign pix_ready  = (r_state == WAIT_PIX);
    assign busy       = (r_state != IDLE) && (r_state != LAST);
    assign frame_done = (r_state == LAST);
    assign pix_index  = r_idx[9:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and byte-load decode
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_byte = '0;
        unique case (r_state)
            IDLE: if (frame_start) begin
                w_load = 1'b1; w_byte = 8'h5A; w_next = HDR;
            end
            HDR: if (w_tx_ready) begin
                w_load = 1'b1;
                w_byte = (r_byte_cnt == 2'd0) ? 8'h5A : (r_byte_cnt == 2'd1) ? 8'h02 : 8'h06;
                if (r_byte_cnt == 2'd2) w_next = WAIT_PIX;
            end
            WAIT_PIX: if (pix_valid) w_next = PIX_LO;
            PIX_LO: if (w_tx_ready) begin
                w_load = 1'b1; w_byte = r_pix[7:0]; w_next = PIX_HI;
            end
            PIX_HI: if (w_tx_ready) begin
                w_load = 1'b1; w_byte = r_pix[15:8];
                w_next = (r_idx < PIX_END) ? WAIT_PIX : AMB_LO;
            end
            AMB_LO: if (w_tx_ready) begin
                w_load = 1'b1; w_byte = r_amb[7:0]; w_next = AMB_HI;
            end
            AMB_HI: if (w_tx_ready) begin
                w_load = 1'b1; w_byte = r_amb[15:8]; w_next = CHK_LO;
            end
            CHK_LO: if (w_tx_ready) begin
                w_load = 1'b1; w_byte = w_chk[7:0]; w_next = CHK_HI;
            end
            // Stays here until the final byte's stop bit has fully elapsed
            CHK_HI: begin
                if (r_byte_cnt == 2'd0) begin
                    if (w_tx_ready) begin
                        w_load = 1'b1; w_byte = w_chk[15:8];
                    end
                end else if (w_byte_end) begin
                    w_next = LAST;
                end
            end
            LAST:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // UART shifter: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_shift   <= '1;
            r_bit_cnt <= '0;
            r_clk_cnt <= '0;
        end else if (w_load) begin
            r_active  <= 1'b1;
            r_shift   <= {1'b1, w_byte, 1'b0};
            r_bit_cnt <= '0;
            r_clk_cnt <= '0;
        end else if (r_active) begin
            if (r_clk_cnt == CNT_MAX) begin
                r_clk_cnt <= '0;
                r_shift   <= {1'b1, r_shift[9:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
                if (r_bit_cnt == 4'd9) r_active <= 1'b0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end
    end

    // Frame data path: ambient capture, pixel capture, checksum and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_amb      <= '0;
            r_pix      <= '0;
            r_sum      <= '0;
            r_idx      <= '0;
            r_byte_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (frame_start) begin
                    r_amb      <= ambient;
                    r_sum      <= '0;
                    r_idx      <= '0;
                    r_byte_cnt <= '0;
                end
                HDR:      if (w_load) r_byte_cnt <= r_byte_cnt + 2'd1;
                WAIT_PIX: if (pix_valid) begin
                    r_pix <= pix_data;
                    r_sum <= r_sum + pix_data;
                    r_idx <= r_idx + 11'd1;
                end
                CHK_LO:   if (w_load) r_byte_cnt <= 2'd0;
                CHK_HI:   if (w_load) r_byte_cnt <= 2'd1;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_ircam_frame_tx.sv
// Directed bench for ircam_frame_tx: a full-size instance and a 16-pixel instance
// share stimulus; a bench UART receiver decodes whichever line is selected.
module tb_ircam_frame_tx;

    localparam int CPB  = 4;
    localparam int NP_L = 768;
    localparam int NP_S = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, frame_start = 1'b0, pix_valid = 1'b0, sel = 1'b0;
    logic [15:0] ambient = '0, pix_data = '0;
    logic        rdy_l, rdy_s, tx_l, tx_s, busy_l, busy_s, done_l, done_s;
    logic [9:0]  idx_l, idx_s;
    logic        w_line, w_ready, w_busy, w_done;
    logic [9:0]  w_idx;

    assign w_line  = sel ? tx_s   : tx_l;
    assign w_ready = sel ? rdy_s  : rdy_l;
    assign w_busy  = sel ? busy_s : busy_l;
    assign w_done  = sel ? done_s : done_l;
    assign w_idx   = sel ? idx_s  : idx_l;

    ircam_frame_tx #(.CLKS_PER_BIT(CPB), .NUM_PIX(NP_L)) u_large (
        .clk(clk), .rst(rst), .frame_start(frame_start & ~sel), .ambient(ambient),
        .pix_data(pix_data), .pix_valid(pix_valid & ~sel), .pix_ready(rdy_l),
        .pix_index(idx_l), .UART_TX(tx_l), .busy(busy_l), .frame_done(done_l));

    ircam_frame_tx #(.CLKS_PER_BIT(CPB), .NUM_PIX(NP_S)) u_small (
        .clk(clk), .rst(rst), .frame_start(frame_start & sel), .ambient(ambient),
        .pix_data(pix_data), .pix_valid(pix_valid & sel), .pix_ready(rdy_s),
        .pix_index(idx_s), .UART_TX(tx_s), .busy(busy_s), .frame_done(done_s));

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench UART receiver: every bit must hold one level for CPB cycles, stop bit high
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_err = 0;
    logic [7:0] rx_b;
    logic       rx_v, rx_bad;
    always begin
        @(negedge clk);
        if (w_line === 1'b0) begin
            rx_t.push_back(cyc);
            rx_bad = 1'b0;
            rx_b   = '0;
            rx_v   = 1'b0;
            for (int i = 0; i < 10; i++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (i != 0 || c != 0) @(negedge clk);
                    if (c == 0) rx_v = w_line;
                    else if (w_line !== rx_v) rx_bad = 1'b1;
                end
                if (i >= 1 && i <= 8) rx_b[i-1] = rx_v;
            end
            if (rx_v !== 1'b1) rx_bad = 1'b1;
            if (rx_bad) rx_err++;
            rx_q.push_back(rx_b);
        end
    end

    // frame_done monitor
    int   done_cnt = 0, done_cyc = 0;
    logic busy_at_done = 1'b1;
    always @(negedge clk) begin
        if (w_done === 1'b1) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = w_busy;
        end
    end

    // Expected-frame model
    logic [7:0]  exp_q[$];
    logic [15:0] exp_chk;
    task automatic build_exp(input int n, input logic [15:0] amb, input logic [15:0] base,
                             input logic [15:0] step);
        logic [15:0] s, v;
        exp_q.delete();
        exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h02); exp_q.push_back(8'h06);
        s = 16'h5A5A + 16'h0602;
        for (int k = 0; k < n; k++) begin
            v = base + 16'(k) * step;
            exp_q.push_back(v[7:0]); exp_q.push_back(v[15:8]);
            s = s + v;
        end
        s = s + amb;
        exp_q.push_back(amb[7:0]); exp_q.push_back(amb[15:8]);
        exp_q.push_back(s[7:0]);   exp_q.push_back(s[15:8]);
        exp_chk = s;
    endtask

    function automatic int n_bad(input int base);
        int nb = 0;
        if (rx_q.size() - base != exp_q.size()) nb++;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= rx_q.size() || rx_q[base+i] !== exp_q[i]) nb++;
        return nb;
    endfunction

    // Per-run observations
    int   rx_base, rxe_base, done_base;
    logic st_line, st_busy, stall_bad;
    logic rs_line, rs_busy, rs_ready;
    logic [9:0] rs_idx;

    // mode 0 plain, 1 stall at pixel 10, 2 extra frame_start mid-frame, 3 reset mid-pixel
    task automatic run_frame(input logic s, input int n, input logic [15:0] amb,
                             input logic [15:0] base, input logic [15:0] step, input int mode);
        int k, t, stall, rcnt;
        sel = s;
        rx_base = rx_q.size(); rxe_base = rx_err; done_base = done_cnt;
        @(negedge clk);
        ambient = amb;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        ambient = 16'hDEAD;
        st_line = w_line; st_busy = w_busy;
        k = 0; t = 0; stall = 0; rcnt = 0; stall_bad = 1'b0;
        while (k < n && t < n * 100 + 1000) begin
            pix_data  = base + 16'(k) * step;
            pix_valid = 1'b1;
            frame_start = (mode == 2 && t == 300);
            if (frame_start) ambient = 16'h1111;
            if (mode == 1 && k == 10 && w_ready && stall < 100) begin
                pix_valid = 1'b0;
                stall++;
                if (w_idx !== 10'd10) stall_bad = 1'b1;
                if (stall > 60 && w_line !== 1'b1) stall_bad = 1'b1;
            end
            if (mode == 3 && k == 12) begin
                rcnt++;
                if (rcnt == 17) begin
                    rst = 1'b1; frame_start = 1'b1;
                    @(negedge clk);
                    rs_line = w_line; rs_busy = w_busy; rs_ready = w_ready; rs_idx = w_idx;
                    rst = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
                    break;
                end
            end
            if (w_ready && pix_valid) k++;
            @(negedge clk);
            t++;
        end
        pix_valid = 1'b0;
        frame_start = 1'b0;
        if (mode != 3) begin
            t = 0;
            while (done_cnt == done_base && t < 2000) begin
                @(negedge clk);
                t++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b1; pix_valid = 1'b1; sel = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_l, tx_s, busy_l, busy_s, done_l, done_s, rdy_l, rdy_s} !== 8'b1100_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 11000000",
                     {tx_l, tx_s, busy_l, busy_s, done_l, done_s, rdy_l, rdy_s});
        end
        checks++;
        if (idx_l !== 10'd0 || idx_s !== 10'd0) begin
            errors++;
            $display("FAIL reset_index: got %0d/%0d want 0/0", idx_l, idx_s);
        end
        rst = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_l !== 1'b0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_dominates_start: busy got %b%b want 00", busy_l, busy_s);
        end
    endtask

    task automatic test_small_frame();
        build_exp(NP_S, 16'h0A28, 16'h1234, 16'h0101);
        run_frame(1'b1, NP_S, 16'h0A28, 16'h1234, 16'h0101, 0);
        checks++;
        if (st_line !== 1'b0 || st_busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start_bit: line/busy got %b/%b want 0/1", st_line, st_busy);
        end
        checks++;
        if (n_bad(rx_base) !== 0) begin
            errors++;
            $display("FAIL small_bytes: got %0d bad bytes want 0", n_bad(rx_base));
        end
        checks++;
        if (rx_err - rxe_base !== 0) begin
            errors++;
            $display("FAIL small_framing: got %0d bad bytes want 0", rx_err - rxe_base);
        end
        checks++;
        if (done_cnt - done_base !== 1 || done_cyc - rx_t[rx_base] !== 1600) begin
            errors++;
            $display("FAIL small_duration: done=%0d cycles=%0d want 1 and 1600",
                     done_cnt - done_base, done_cyc - rx_t[rx_base]);
        end
        checks++;
        if (busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b want 0", busy_at_done);
        end
    endtask

    task automatic test_stall();
        build_exp(NP_S, 16'h0B0C, 16'h0100, 16'h0011);
        run_frame(1'b1, NP_S, 16'h0B0C, 16'h0100, 16'h0011, 1);
        checks++;
        if (stall_bad !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: got bad=%b want 0 (line high, index 10)", stall_bad);
        end
        checks++;
        if (n_bad(rx_base) !== 0 || rx_err - rxe_base !== 0) begin
            errors++;
            $display("FAIL stall_bytes: got %0d bad/%0d framing want 0/0",
                     n_bad(rx_base), rx_err - rxe_base);
        end
        checks++;
        if (done_cnt - done_base !== 1 || done_cyc - rx_t[rx_base] <= 1600) begin
            errors++;
            $display("FAIL stall_done: done=%0d cycles=%0d want 1 and >1600",
                     done_cnt - done_base, done_cyc - rx_t[rx_base]);
        end
    endtask

    task automatic test_ignore_start();
        build_exp(NP_S, 16'h2222, 16'hA000, 16'h0203);
        run_frame(1'b1, NP_S, 16'h2222, 16'hA000, 16'h0203, 2);
        repeat (100) @(negedge clk);
        checks++;
        if (done_cnt - done_base !== 1 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: done=%0d busy=%b want 1/0", done_cnt - done_base, w_busy);
        end
        checks++;
        if (n_bad(rx_base) !== 0) begin
            errors++;
            $display("FAIL ignore_start_bytes: got %0d bad want 0", n_bad(rx_base));
        end
    endtask

    task automatic test_reset_mid();
        run_frame(1'b1, NP_S, 16'h3333, 16'h0000, 16'h0001, 3);
        checks++;
        if ({rs_line, rs_busy, rs_ready} !== 3'b100 || rs_idx !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_frame: line/busy/ready got %b%b%b idx %0d want 100 idx 0",
                     rs_line, rs_busy, rs_ready, rs_idx);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt - done_base !== 0 || w_line !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_resume: done=%0d line=%b want 0/1", done_cnt - done_base, w_line);
        end
        build_exp(NP_S, 16'h4444, 16'h5000, 16'h0101);
        run_frame(1'b1, NP_S, 16'h4444, 16'h5000, 16'h0101, 0);
        checks++;
        if (n_bad(rx_base) !== 0 || rx_err - rxe_base !== 0 || done_cnt - done_base !== 1) begin
            errors++;
            $display("FAIL after_reset_frame: got %0d bad/%0d framing/%0d done want 0/0/1",
                     n_bad(rx_base), rx_err - rxe_base, done_cnt - done_base);
        end
    endtask

    task automatic test_wrap();
        int last;
        build_exp(NP_S, 16'hFFFF, 16'hFFFF, 16'h0000);
        run_frame(1'b1, NP_S, 16'hFFFF, 16'hFFFF, 16'h0000, 0);
        last = rx_q.size() - 1;
        checks++;
        if (last < 1 || {rx_q[last], rx_q[last-1]} !== 16'h604B) begin
            errors++;
            $display("FAIL wrap_checksum: got %h want 604b", (last < 1) ? 16'h0 : {rx_q[last], rx_q[last-1]});
        end
        checks++;
        if (n_bad(rx_base) !== 0) begin
            errors++;
            $display("FAIL wrap_bytes: got %0d bad want 0", n_bad(rx_base));
        end
    endtask

    task automatic test_full_frame();
        int last;
        build_exp(NP_L, 16'h0A28, 16'h0BB8, 16'h0000);
        run_frame(1'b0, NP_L, 16'h0A28, 16'h0BB8, 16'h0000, 0);
        last = rx_q.size() - 1;
        checks++;
        if (rx_q.size() - rx_base !== 1544 || n_bad(rx_base) !== 0) begin
            errors++;
            $display("FAIL full_bytes: got %0d bytes %0d bad want 1544/0",
                     rx_q.size() - rx_base, n_bad(rx_base));
        end
        checks++;
        if (last < 1 || {rx_q[last], rx_q[last-1]} !== 16'h9284) begin
            errors++;
            $display("FAIL full_checksum: got %h want 9284", (last < 1) ? 16'h0 : {rx_q[last], rx_q[last-1]});
        end
        checks++;
        if (rx_err - rxe_base !== 0) begin
            errors++;
            $display("FAIL full_framing: got %0d bad want 0", rx_err - rxe_base);
        end
        checks++;
        if (done_cnt - done_base !== 1 || done_cyc - rx_t[rx_base] !== 61760) begin
            errors++;
            $display("FAIL full_duration: done=%0d cycles=%0d want 1 and 61760",
                     done_cnt - done_base, done_cyc - rx_t[rx_base]);
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_wrap();
        test_full_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
